// File: rtl/data_mem_mmio.sv
// Byte-addressed little-endian data memory for the RV32I MEM stage, with fault
// detection and a memory-mapped UART transmit FIFO plus status register.
module data_mem_mmio #(
  parameter int          SIZE_BYTES  = 512,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [31:0] UART_ADDR   = 32'h1000_0000,
  parameter logic [31:0] STATUS_ADDR = 32'h1000_0004,
  parameter              INIT_FILE   = ""
) (
  input  logic        clka,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  mem_u_b_h_w,
  output logic        ready,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        fault,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  output logic [1:0]  o_dbg_state
);

  localparam int AW = $clog2(SIZE_BYTES);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESP    = 2'd1,
    WAIT_TX = 2'd2
  } state_t;

  // Handshake: a request is taken on a rising edge where req && ready; the
  // matching response is rvalid high for exactly one cycle, fault qualifying it.
  state_t          r_state;
  logic            r_ready;
  logic            r_rvalid;
  logic [31:0]     r_rdata;
  logic            r_fault;
  logic [7:0]      r_pend_byte;

  logic [7:0]      r_mem [SIZE_BYTES];
  logic [7:0]      r_fifo [FIFO_DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;

  logic            w_accept;
  logic            w_is_word;
  logic            w_is_half;
  logic            w_is_uart;
  logic            w_is_stat;
  logic            w_mmio;
  logic            w_fault;
  logic            w_uart_st;
  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic            w_push;
  logic            w_space;
  logic [7:0]      w_push_data;
  logic [AW-1:0]   w_idx;
  logic [3:0]      w_lane_en;
  logic [7:0]      w_b [4];
  logic            w_sext;
  logic [31:0]     w_rd_ram;
  logic [31:0]     w_status;
  logic [31:0]     w_load_result;

  assign w_accept  = req && (r_state == IDLE);
  assign w_is_word = mem_u_b_h_w[1];
  assign w_is_half = !mem_u_b_h_w[1] && mem_u_b_h_w[0];
  assign w_sext    = !mem_u_b_h_w[2];
  assign w_is_uart = (addr == UART_ADDR);
  assign w_is_stat = (addr == STATUS_ADDR);
  assign w_mmio    = w_is_uart || w_is_stat;

  assign w_fault = (w_is_word && (addr[1:0] != 2'b00)) ||
                   (w_is_half && addr[0]) ||
                   (!w_mmio && (addr >= 32'(SIZE_BYTES))) ||
                   (we && w_is_stat) ||
                   (w_mmio && !w_is_word);

  assign w_uart_st = we && w_is_uart && !w_fault;

  assign w_full        = (r_count == CW'(FIFO_DEPTH));
  assign w_empty       = (r_count == '0);
  assign uart_tx_valid = !w_empty;
  assign uart_tx_data  = w_empty ? 8'h00 : r_fifo[r_rptr];
  assign w_pop         = uart_tx_valid && uart_tx_ready;
  // A pop in the same cycle frees the slot a stalled store is waiting for.
  assign w_space       = !w_full || w_pop;
  assign w_push        = (w_accept && w_uart_st && !w_full) ||
                         ((r_state == WAIT_TX) && w_space);
  assign w_push_data   = (r_state == WAIT_TX) ? r_pend_byte : wdata[7:0];

  assign w_idx     = addr[AW-1:0];
  assign w_lane_en = w_is_word ? 4'b1111 : (w_is_half ? 4'b0011 : 4'b0001);

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_b[k] = r_mem[w_idx + AW'(k)];
    end
  end

  always_comb begin
    w_rd_ram = '0;
    if (w_is_word) begin
      w_rd_ram = {w_b[3], w_b[2], w_b[1], w_b[0]};
    end else if (w_is_half) begin
      w_rd_ram = {{16{w_sext && w_b[1][7]}}, w_b[1], w_b[0]};
    end else begin
      w_rd_ram = {{24{w_sext && w_b[0][7]}}, w_b[0]};
    end
  end

  assign w_status = {22'b0, 8'(r_count), w_full, w_empty};

  always_comb begin
    w_load_result = '0;
    if (!w_fault && !we) begin
      if (w_is_stat)      w_load_result = w_status;
      else if (!w_is_uart) w_load_result = w_rd_ram;
    end
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ready     <= 1'b1;
      r_rvalid    <= 1'b0;
      r_rdata     <= '0;
      r_fault     <= 1'b0;
      r_pend_byte <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req) begin
            r_ready     <= 1'b0;
            r_rdata     <= w_load_result;
            r_fault     <= w_fault;
            r_pend_byte <= wdata[7:0];
            if (w_uart_st && w_full) begin
              r_state <= WAIT_TX;
            end else begin
              r_state  <= RESP;
              r_rvalid <= 1'b1;
            end
          end
        end
        RESP: begin
          r_state  <= IDLE;
          r_rvalid <= 1'b0;
          r_fault  <= 1'b0;
          r_ready  <= 1'b1;
        end
        WAIT_TX: begin
          if (w_space) begin
            r_state  <= RESP;
            r_rvalid <= 1'b1;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_ready  <= 1'b1;
          r_rvalid <= 1'b0;
          r_fault  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clka) begin
    if (w_push) r_fifo[r_wptr] <= w_push_data;
  end

  // Faulting and MMIO accesses never reach the array.
  always_ff @(posedge clka) begin
    if (w_accept && we && !w_fault && !w_mmio) begin
      for (int k = 0; k < 4; k++) begin
        if (w_lane_en[k]) r_mem[w_idx + AW'(k)] <= wdata[8*k +: 8];
      end
    end
  end

  assign ready       = r_ready;
  assign rvalid      = r_rvalid;
  assign rdata       = r_rdata;
  assign fault       = r_fault;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_data_mem_mmio.sv
// Directed, table-driven bench for data_mem_mmio: RAM access vectors, faults,
// UART FIFO fill/stall/drain ordering and reset during a stalled UART store.
module tb_data_mem_mmio;

  localparam logic [31:0] UART   = 32'h1000_0000;
  localparam logic [31:0] STATUS = 32'h1000_0004;
  localparam logic [2:0] M_W  = 3'b010;
  localparam logic [2:0] M_HS = 3'b001;
  localparam logic [2:0] M_HU = 3'b101;
  localparam logic [2:0] M_BS = 3'b000;
  localparam logic [2:0] M_BU = 3'b100;

  logic        clka = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [2:0]  mode = '0;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;
  logic        fault;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready = 1'b0;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  typedef struct {
    string       name;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  m;
    logic [31:0] exp_rd;
    logic        exp_f;
  } vec_t;

  vec_t vecs[$];

  data_mem_mmio #(.SIZE_BYTES(512), .FIFO_DEPTH(4)) dut (
    .clka(clka), .rst_n(rst_n), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .mem_u_b_h_w(mode), .ready(ready), .rvalid(rvalid),
    .rdata(rdata), .fault(fault), .uart_tx_data(uart_tx_data),
    .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clka = ~clka;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Bytes leave the FIFO at the edge following this sample point.
  always @(negedge clka) begin
    #2;
    if (rst_n && uart_tx_valid && uart_tx_ready) got_q.push_back(uart_tx_data);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] m, input logic txr);
    @(negedge clka);
    req = 1'b1; we = w; addr = a; wdata = d; mode = m;
    if (txr) uart_tx_ready = 1'b1;
    @(posedge clka);
    #1;
    req = 1'b0;
    if (txr) uart_tx_ready = 1'b0;
  endtask

  task automatic xact(input string name, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [2:0] m,
                      input logic [31:0] exp_rd, input logic exp_f, input logic txr);
    int lat;
    check({name, " ready_before"}, 32'(ready), 32'd1);
    issue(w, a, d, m, txr);
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clka);
      if (rvalid) begin
        lat = c;
        break;
      end
    end
    check({name, " latency"}, 32'(lat), 32'd1);
    check({name, " fault"}, 32'(fault), 32'(exp_f));
    if (!w || exp_f) check({name, " rdata"}, rdata, exp_rd);
    check({name, " ready_resp"}, 32'(ready), 32'd0);
    @(negedge clka);
    check({name, " ready_after"}, 32'(ready), 32'd1);
    check({name, " rvalid_pulse"}, 32'(rvalid), 32'd0);
  endtask

  task automatic drain(input string name);
    int done;
    done = 0;
    @(negedge clka);
    uart_tx_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clka);
      if (!uart_tx_valid) begin
        done = 1;
        break;
      end
    end
    uart_tx_ready = 1'b0;
    check({name, " drain_done"}, 32'(done), 32'd1);
    check({name, " drain_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check($sformatf("%s byte%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
    end
    exp_q.delete();
    got_q.delete();
  endtask

  function automatic vec_t mk(input string n, input logic w, input logic [31:0] a,
                              input logic [31:0] d, input logic [2:0] m,
                              input logic [31:0] r, input logic f);
    vec_t v;
    v.name = n; v.w = w; v.a = a; v.d = d; v.m = m; v.exp_rd = r; v.exp_f = f;
    return v;
  endfunction

  initial begin
    vecs.push_back(mk("st_w0",      1, 32'h000, 32'h0A0B_0C0D, M_W,  32'h0, 0));
    vecs.push_back(mk("st_w4",      1, 32'h004, 32'h1122_3344, M_W,  32'h0, 0));
    vecs.push_back(mk("st_w10",     1, 32'h010, 32'h8765_4321, M_W,  32'h0, 0));
    vecs.push_back(mk("ld_w10",     0, 32'h010, 32'h0, M_W,  32'h8765_4321, 0));
    vecs.push_back(mk("ld_hs12",    0, 32'h012, 32'h0, M_HS, 32'hFFFF_8765, 0));
    vecs.push_back(mk("ld_hu12",    0, 32'h012, 32'h0, M_HU, 32'h0000_8765, 0));
    vecs.push_back(mk("ld_bs13",    0, 32'h013, 32'h0, M_BS, 32'hFFFF_FF87, 0));
    vecs.push_back(mk("st_b11",     1, 32'h011, 32'h1234_56AA, M_BS, 32'h0, 0));
    vecs.push_back(mk("ld_w10b",    0, 32'h010, 32'h0, M_W,  32'h8765_AA21, 0));
    vecs.push_back(mk("ld_bu11",    0, 32'h011, 32'h0, M_BU, 32'h0000_00AA, 0));
    vecs.push_back(mk("ld_hs10",    0, 32'h010, 32'h0, M_HS, 32'hFFFF_AA21, 0));
    vecs.push_back(mk("ld_hu06",    0, 32'h006, 32'h0, M_HU, 32'h0000_1122, 0));
    vecs.push_back(mk("f_ld_w02",   0, 32'h002, 32'h0, M_W,  32'h0, 1));
    vecs.push_back(mk("f_ld_hs03",  0, 32'h003, 32'h0, M_HS, 32'h0, 1));
    vecs.push_back(mk("f_st_h05",   1, 32'h005, 32'h0000_BEEF, M_HS, 32'h0, 1));
    vecs.push_back(mk("ld_w04",     0, 32'h004, 32'h0, M_W,  32'h1122_3344, 0));
    vecs.push_back(mk("f_ld_w200",  0, 32'h200, 32'h0, M_W,  32'h0, 1));
    vecs.push_back(mk("f_st_w200",  1, 32'h200, 32'hDEAD_BEEF, M_W, 32'h0, 1));
    vecs.push_back(mk("ld_w0",      0, 32'h000, 32'h0, M_W,  32'h0A0B_0C0D, 0));
    vecs.push_back(mk("st_w1fc",    1, 32'h1FC, 32'h80FF_00FF, M_W, 32'h0, 0));
    vecs.push_back(mk("ld_bs1ff",   0, 32'h1FF, 32'h0, M_BS, 32'hFFFF_FF80, 0));
    vecs.push_back(mk("ld_hu1fe",   0, 32'h1FE, 32'h0, M_HU, 32'h0000_80FF, 0));
    vecs.push_back(mk("f_st_b_uart",1, UART,    32'h41,  M_BS, 32'h0, 1));
    vecs.push_back(mk("stat_empty", 0, STATUS,  32'h0, M_W,  32'h0000_0001, 0));
    vecs.push_back(mk("ld_uart",    0, UART,    32'h0, M_W,  32'h0, 0));
    vecs.push_back(mk("f_st_stat",  1, STATUS,  32'h5, M_W,  32'h0, 1));
    vecs.push_back(mk("f_ld_h_stat",0, STATUS,  32'h0, M_HS, 32'h0, 1));
    vecs.push_back(mk("f_ld_oor",   0, 32'h1000_0008, 32'h0, M_W, 32'h0, 1));

    repeat (3) @(negedge clka);
    check("rst ready", 32'(ready), 32'd1);
    check("rst rvalid", 32'(rvalid), 32'd0);
    check("rst rdata", rdata, 32'd0);
    check("rst fault", 32'(fault), 32'd0);
    check("rst tx_valid", 32'(uart_tx_valid), 32'd0);
    check("rst tx_data", 32'(uart_tx_data), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      xact(vecs[i].name, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].m,
           vecs[i].exp_rd, vecs[i].exp_f, 1'b0);
    end
    check("tbl no_tx", 32'(uart_tx_valid), 32'd0);

    // Fill the FIFO with the consumer stalled, then overflow by one.
    for (int i = 0; i < 4; i++) begin
      xact($sformatf("fill%0d", i), 1, UART, 32'(8'h41 + i), M_W, 32'h0, 0, 1'b0);
      exp_q.push_back(8'(8'h41 + i));
    end
    check("fill head", 32'(uart_tx_data), 32'h41);
    xact("stat_full", 0, STATUS, 32'h0, M_W, 32'h0000_0012, 0, 1'b0);
    issue(1, UART, 32'h45, M_W, 1'b0);
    exp_q.push_back(8'h45);
    for (int c = 0; c < 3; c++) begin
      @(negedge clka);
      check($sformatf("wait%0d rvalid", c), 32'(rvalid), 32'd0);
      check($sformatf("wait%0d ready", c), 32'(ready), 32'd0);
    end
    uart_tx_ready = 1'b1;
    @(negedge clka);
    uart_tx_ready = 1'b0;
    check("E ack rvalid", 32'(rvalid), 32'd1);
    check("E ack fault", 32'(fault), 32'd0);
    check("E ack ready", 32'(ready), 32'd0);
    check("E head", 32'(uart_tx_data), 32'h42);
    @(negedge clka);
    check("E ready_after", 32'(ready), 32'd1);
    drain("ABCDE");
    xact("stat_drained", 0, STATUS, 32'h0, M_W, 32'h0000_0001, 0, 1'b0);

    // Push and pop on the same edge with two entries queued.
    xact("pp_F", 1, UART, 32'h46, M_W, 32'h0, 0, 1'b0);
    xact("pp_G", 1, UART, 32'h47, M_W, 32'h0, 0, 1'b0);
    exp_q.push_back(8'h46);
    exp_q.push_back(8'h47);
    xact("pp_H", 1, UART, 32'h48, M_W, 32'h0, 0, 1'b1);
    exp_q.push_back(8'h48);
    xact("pp_stat", 0, STATUS, 32'h0, M_W, 32'h0000_0008, 0, 1'b0);
    check("pp head", 32'(uart_tx_data), 32'h47);
    drain("FGH");

    // Reset while a UART store is stalled in WAIT_TX.
    xact("rs_st40", 1, 32'h040, 32'hCAFE_F00D, M_W, 32'h0, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      xact($sformatf("rs_fill%0d", i), 1, UART, 32'(8'h50 + i), M_W, 32'h0, 0, 1'b0);
    end
    issue(1, UART, 32'h5A, M_W, 1'b0);
    @(negedge clka);
    check("rs wait ready", 32'(ready), 32'd0);
    check("rs wait rvalid", 32'(rvalid), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    check("rs ready", 32'(ready), 32'd1);
    check("rs rvalid", 32'(rvalid), 32'd0);
    check("rs tx_valid", 32'(uart_tx_valid), 32'd0);
    check("rs tx_data", 32'(uart_tx_data), 32'd0);
    @(negedge clka);
    rst_n = 1'b1;
    @(negedge clka);
    check("rs no_resp", 32'(rvalid), 32'd0);
    xact("rs_stat", 0, STATUS, 32'h0, M_W, 32'h0000_0001, 0, 1'b0);
    xact("rs_ld40", 0, 32'h040, 32'h0, M_W, 32'hCAFE_F00D, 0, 1'b0);
    check("rs got_none", 32'(got_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
